rv_mdu: RTL

//   Iterative RV32M multiply/divide unit in the execute stage, beside the ALU, on the same operand buses.

---
 rtl/rv_mdu.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rv_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on magnitudes, with the sign applied when the last iteration retires.
module rv_mdu #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned MDU_OP_W = 3
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                mdu_req_i,
   input  logic [MDU_OP_W-1:0] mdu_op_i,
   input  logic [XLEN-1:0]     mdu_port_a_i,
   input  logic [XLEN-1:0]     mdu_port_b_i,
   input  logic                mdu_kill_i,
   output logic                mdu_ready_o,
   output logic                mdu_busy_o,
   output logic                mdu_result_valid_o,
   input  logic                mdu_result_ready_i,
   output logic [XLEN-1:0]     mdu_result_o
);

   localparam int unsigned CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
   typedef enum logic [MDU_OP_W-1:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mdu_op_e;

   state_e              state_q, state_d;
   mdu_op_e             op_q, op_d, op_in;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;
   logic                neg_q, neg_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                a_signed, b_signed, a_neg, b_neg, in_is_div;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic [XLEN:0]       mul_sum, div_r, div_diff;
   logic [2*XLEN-1:0]   iter_next, prod;
   logic [XLEN-1:0]     quo, rem;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      neg_d    = neg_q;
      result_d = result_q;

      op_in     = mdu_op_e'(mdu_op_i);
      in_is_div = mdu_op_i[2];
      a_signed  = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                  (op_in == OP_DIV) || (op_in == OP_REM);
      b_signed  = (op_in == OP_MUL) || (op_in == OP_MULH) ||
                  (op_in == OP_DIV) || (op_in == OP_REM);
      a_neg     = a_signed && mdu_port_a_i[XLEN-1];
      b_neg     = b_signed && mdu_port_b_i[XLEN-1];
      a_mag     = a_neg ? -mdu_port_a_i : mdu_port_a_i;
      b_mag     = b_neg ? -mdu_port_b_i : mdu_port_b_i;

      // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_r     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_r - {1'b0, opnd_q};
      if (op_q[2])
         iter_next = div_diff[XLEN] ? {div_r[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
         iter_next = {mul_sum, acc_q[XLEN-1:1]};

      prod = neg_q ? -iter_next : iter_next;
      quo  = neg_q ? -iter_next[XLEN-1:0] : iter_next[XLEN-1:0];
      rem  = neg_q ? -iter_next[2*XLEN-1:XLEN] : iter_next[2*XLEN-1:XLEN];

      unique case (state_q)
         S_IDLE: begin
            if (mdu_req_i) begin
               op_d = op_in;
               if (in_is_div && (mdu_port_b_i == '0)) begin
                  result_d = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : mdu_port_a_i;
                  state_d  = S_DONE;
               end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                            (mdu_port_a_i == INT_MIN) && (mdu_port_b_i == '1)) begin
                  result_d = (op_in == OP_DIV) ? INT_MIN : '0;
                  state_d  = S_DONE;
               end else begin
                  cnt_d   = CNT_W'(XLEN-1);
                  opnd_d  = in_is_div ? b_mag : a_mag;
                  acc_d   = {{XLEN{1'b0}}, (in_is_div ? a_mag : b_mag)};
                  neg_d   = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            acc_d = iter_next;
            if (cnt_q == '0) begin
               state_d = S_DONE;
               case (op_q)
                  OP_MUL:                       result_d = prod[XLEN-1:0];
                  OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod[2*XLEN-1:XLEN];
                  OP_DIV, OP_DIVU:              result_d = quo;
                  OP_REM, OP_REMU:              result_d = rem;
               endcase
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            if (mdu_result_ready_i)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (mdu_kill_i)
         state_d = S_IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         op_q     <= OP_MUL;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      mdu_ready_o        = (state_q == S_IDLE);
      mdu_busy_o         = (state_q != S_IDLE);
      mdu_result_valid_o = (state_q == S_DONE);
      mdu_result_o       = result_q;
   end

endmodule
